// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 state encoding and default parameters
package crc_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

endpackage

// File: rtl/crc_table.sv
// rtl/crc_table.sv - 256x8 synchronous CRC-8 lookup ROM, MSB-first, non-reflected
module crc_table #(
  parameter logic [7:0] POLYNOMIAL = 8'h07
) (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] entry(input logic [7:0] idx);
    logic [7:0] c;
    c = idx;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ POLYNOMIAL) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic [7:0] rom [256];

  // Contents are constants; no reset on the ROM or its read register.
  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign rom[g] = entry(8'(g));
  end

  always_ff @(posedge clk_i) begin
    data_o <= rom[addr_i];
  end

endmodule

// File: rtl/crc8_checker.sv
// rtl/crc8_checker.sv - receive-side CRC-8 frame verifier with registered per-frame result
module crc8_checker
  import crc_pkg::*;
#(
  parameter logic [7:0]  POLYNOMIAL = CRC8_POLY_DEFAULT,
  parameter logic [7:0]  INIT       = CRC8_INIT_DEFAULT,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             result_ok_o,
  output logic             result_short_o,
  output logic [7:0]       result_crc_o,
  output logic [LEN_W-1:0] result_len_o
);

  state_e           state, state_nxt;
  logic [7:0]       crc;
  logic [7:0]       table_addr;
  logic [7:0]       table_data;
  logic [LEN_W-1:0] len;
  logic             last_q;
  logic             accept;
  logic             consume;

  assign accept     = (state == ST_ACCEPT) && valid_i;
  assign consume    = (state == ST_REPORT) && result_ready_i;
  assign table_addr = crc ^ data_i;

  crc_table #(.POLYNOMIAL(POLYNOMIAL)) u_table (
    .clk_i  (clk_i),
    .addr_i (table_addr),
    .data_o (table_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_ACCEPT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT: if (valid_i) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = last_q ? ST_REPORT : ST_ACCEPT;
      ST_REPORT: if (result_ready_i) state_nxt = ST_ACCEPT;
      default:   state_nxt = ST_ACCEPT;
    endcase
  end

  always_comb begin
    ready_o        = (state == ST_ACCEPT);
    result_valid_o = (state == ST_REPORT);
  end

  // Result fields are captured from the ROM output in the final LOOKUP cycle,
  // so they already hold the residue that includes the CRC byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc            <= INIT;
      len            <= '0;
      last_q         <= 1'b0;
      result_ok_o    <= 1'b0;
      result_short_o <= 1'b0;
      result_crc_o   <= 8'h00;
      result_len_o   <= '0;
    end else begin
      if (accept) begin
        last_q <= last_i;
        if (len != '1) len <= len + 1'b1;
      end
      if (state == ST_LOOKUP) begin
        crc <= table_data;
        if (last_q) begin
          result_ok_o    <= (table_data == 8'h00) && (len >= LEN_W'(2));
          result_short_o <= (len < LEN_W'(2));
          result_crc_o   <= table_data;
          result_len_o   <= len;
        end
      end
      if (consume) begin
        crc            <= INIT;
        len            <= '0;
        result_ok_o    <= 1'b0;
        result_short_o <= 1'b0;
        result_crc_o   <= 8'h00;
        result_len_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_crc8_checker.sv
// tb/tb_crc8_checker.sv - scoreboard bench for crc8_checker
module tb_crc8_checker;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        result_ok_o;
  logic        result_short_o;
  logic [7:0]  result_crc_o;
  logic [15:0] result_len_o;

  crc8_checker dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .last_i         (last_i),
    .ready_o        (ready_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_ok_o    (result_ok_o),
    .result_short_o (result_short_o),
    .result_crc_o   (result_crc_o),
    .result_len_o   (result_len_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        ok;
    logic        short_f;
    logic [7:0]  crc;
    logic [15:0] len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bit-serial reference: MSB-first, non-reflected, poly 07, init 00, no final XOR.
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (tx[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ tx[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    valid_i = 1'b1;
    data_i  = b;
    last_i  = l;
    t = 0;
    while (!ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    data_i  = $urandom_range(255);
    last_i  = $urandom_range(1);
  endtask

  task automatic send_frame();
    exp_t e;
    foreach (tx[i]) send_byte(tx[i], i == tx.size() - 1);
    e.crc     = model_crc();
    e.len     = 16'(tx.size());
    e.short_f = (tx.size() < 2);
    e.ok      = (e.crc == 8'h00) && (tx.size() >= 2);
    sb.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    int t;
    t = 0;
    while (!result_valid_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) check({tag, "_result_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    wait_result(tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_ok"},    32'(result_ok_o),    32'(e.ok));
    check({tag, "_short"}, 32'(result_short_o), 32'(e.short_f));
    check({tag, "_crc"},   32'(result_crc_o),   32'(e.crc));
    check({tag, "_len"},   32'(result_len_o),   32'(e.len));
    check({tag, "_ready_low"}, 32'(ready_o), 32'd0);
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    check({tag, "_valid_cleared"}, 32'(result_valid_o), 32'd0);
  endtask

  task automatic load_check_frame(input logic [7:0] crc_byte);
    tx = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, crc_byte};
  endtask

  initial begin
    exp_t e;

    repeat (3) @(negedge clk_i);
    check("rst_ready",  32'(ready_o),        32'd1);
    check("rst_valid",  32'(result_valid_o), 32'd0);
    check("rst_fields", {7'd0, result_ok_o, result_short_o, result_crc_o, result_len_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Good check string frame, then corrupted CRC byte
    load_check_frame(8'hF4);
    send_frame();
    collect("good_frame");
    load_check_frame(8'hF5);
    send_frame();
    collect("bad_frame");

    // Two-byte frame with handshake timing observed cycle by cycle
    valid_i = 1'b1; data_i = 8'h01; last_i = 1'b0;
    check("rdy_pat0", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    check("rdy_pat1", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    @(negedge clk_i);
    check("rdy_pat2", 32'(ready_o), 32'd1);
    valid_i = 1'b1; data_i = 8'h07; last_i = 1'b1;
    @(negedge clk_i);
    check("rdy_pat3", 32'(ready_o), 32'd0);
    valid_i = 1'b1; data_i = 8'hAA; last_i = 1'b0;
    check("valid_early", 32'(result_valid_o), 32'd0);
    tx = {8'h01, 8'h07};
    e.crc = model_crc(); e.len = 16'd2; e.short_f = 1'b0; e.ok = (e.crc == 8'h00);
    sb.push_back(e);
    @(negedge clk_i);
    check("valid_latency", 32'(result_valid_o), 32'd1);
    valid_i = 1'b0;
    collect("two_byte");

    // Single-byte frame is short regardless of residue
    tx = {8'h00};
    send_frame();
    collect("one_byte");

    // Backpressure: result held, upstream ignored
    load_check_frame(8'hF4);
    send_frame();
    wait_result("hold");
    e = sb[0];
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      data_i  = $urandom_range(255);
      last_i  = $urandom_range(1);
      check("hold_stable",
            {2'd0, result_valid_o, ready_o, result_ok_o, result_short_o, result_crc_o, result_len_o},
            {2'd0, 1'b1, 1'b0, e.ok, e.short_f, e.crc, e.len});
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    collect("hold_release");
    tx = {8'h01, 8'h07};
    send_frame();
    collect("after_hold");

    // Reset in the middle of a frame discards it
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h34, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_ready",  32'(ready_o),        32'd1);
    check("async_rst_valid",  32'(result_valid_o), 32'd0);
    check("async_rst_fields", {7'd0, result_ok_o, result_short_o, result_crc_o, result_len_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tx = {8'h01, 8'h07};
    send_frame();
    collect("after_reset");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
